// File: rtl/isq_sel_ctl_pkg.sv
// Shared sizing constants and types for the issue-queue select controller.
package isq_pkg;

  localparam int unsigned ISQ_DEPTH = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PREG_W    = 6;

  typedef logic [IDX_W-1:0]  isq_idx_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [IDX_W:0]    isq_cnt_t;

  localparam isq_cnt_t CNT_FULL = isq_cnt_t'(ISQ_DEPTH);

endpackage

// File: rtl/isq_sel_ctl_if.sv
// Handshake bundle between the issue-queue controller and its line array / pipeline.
interface isq_sel_ctl_if;
  import isq_pkg::*;

  logic                 flush;
  logic                 alloc_req;
  preg_t                alloc_pdst;
  logic                 alloc_gnt;
  isq_idx_t             alloc_idx;
  logic                 wb_vld;
  preg_t                wb_preg;
  logic [ISQ_DEPTH-1:0] lin_inst_rdy;
  logic [ISQ_DEPTH-1:0] lin_vld;
  logic [ISQ_DEPTH-1:0] lin_rdy_en;
  logic [ISQ_DEPTH-1:0] lin_rdy_val;
  logic                 issue_stall;
  logic                 iss_vld;
  isq_idx_t             iss_idx;
  isq_cnt_t             cnt;
  logic                 full;
  logic                 empty;

  modport master (
    output flush, alloc_req, alloc_pdst, wb_vld, wb_preg, lin_inst_rdy, issue_stall,
    input  alloc_gnt, alloc_idx, lin_vld, lin_rdy_en, lin_rdy_val, iss_vld, iss_idx,
           cnt, full, empty
  );

  modport slave (
    input  flush, alloc_req, alloc_pdst, wb_vld, wb_preg, lin_inst_rdy, issue_stall,
    output alloc_gnt, alloc_idx, lin_vld, lin_rdy_en, lin_rdy_val, iss_vld, iss_idx,
           cnt, full, empty
  );
endinterface

// File: rtl/isq_sel_ctl_age_sel.sv
// Circular priority encoder: first set request bit at or after head, wrapping.
module isq_age_sel
  import isq_pkg::*;
(
  input  logic [ISQ_DEPTH-1:0] req,
  input  isq_idx_t             head,
  output logic                 found,
  output isq_idx_t             idx
);

  isq_idx_t pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < ISQ_DEPTH; k++) begin
      pos = head + isq_idx_t'(k);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/isq_sel_ctl.sv
// Issue-queue controller: age-ordered allocation, ready-flop decode, oldest-ready select, retire.
// Optional ISQ_WB_BYPASS_EN: a writeback matching a same-cycle allocation marks the new line ready.
module isq_sel_ctl
  import isq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  isq_sel_ctl_if.slave bus
);

  isq_idx_t             head, tail;
  isq_cnt_t             cnt_q;
  logic [ISQ_DEPTH-1:0] vld;
  preg_t                pdst_q [ISQ_DEPTH];
  logic                 iss_vld_q;
  isq_idx_t             iss_idx_q;

  logic                 full_c, gnt, retire, sel_found;
  isq_idx_t             sel_idx;
  logic [ISQ_DEPTH-1:0] rdy_en, rdy_val;

  assign full_c = (cnt_q == CNT_FULL);
  assign gnt    = bus.alloc_req & ~full_c & ~bus.flush;
  assign retire = (cnt_q != '0) & ~vld[head];

  isq_age_sel u_age_sel (
    .req   (vld & bus.lin_inst_rdy),
    .head  (head),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Allocation is applied after writeback so it overrides on the same line.
  always_comb begin
    rdy_en  = '0;
    rdy_val = '0;
    for (int unsigned i = 0; i < ISQ_DEPTH; i++) begin
      if (vld[i] && bus.wb_vld && (pdst_q[i] == bus.wb_preg)) begin
        rdy_en[i]  = 1'b1;
        rdy_val[i] = 1'b1;
      end
    end
    if (gnt) begin
      rdy_en[tail] = 1'b1;
`ifdef ISQ_WB_BYPASS_EN
      rdy_val[tail] = bus.wb_vld && (bus.wb_preg == bus.alloc_pdst);
`else
      rdy_val[tail] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      cnt_q     <= '0;
      vld       <= '0;
      iss_vld_q <= 1'b0;
      iss_idx_q <= '0;
    end else if (bus.flush) begin
      head      <= '0;
      tail      <= '0;
      cnt_q     <= '0;
      vld       <= '0;
      iss_vld_q <= 1'b0;
      iss_idx_q <= '0;
    end else begin
      if (gnt) begin
        vld[tail] <= 1'b1;
        tail      <= tail + isq_idx_t'(1);
      end
      if (sel_found && !bus.issue_stall) begin
        vld[sel_idx] <= 1'b0;
        iss_vld_q    <= 1'b1;
        iss_idx_q    <= sel_idx;
      end else begin
        iss_vld_q <= 1'b0;
      end
      if (retire) head <= head + isq_idx_t'(1);
      case ({gnt, retire})
        2'b10:   cnt_q <= cnt_q + isq_cnt_t'(1);
        2'b01:   cnt_q <= cnt_q - isq_cnt_t'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) pdst_q[tail] <= bus.alloc_pdst;
  end

  assign bus.alloc_gnt   = gnt;
  assign bus.alloc_idx   = tail;
  assign bus.lin_vld     = vld;
  assign bus.lin_rdy_en  = rdy_en;
  assign bus.lin_rdy_val = rdy_val;
  assign bus.iss_vld     = iss_vld_q;
  assign bus.iss_idx     = iss_idx_q;
  assign bus.cnt         = cnt_q;
  assign bus.full        = full_c;
  assign bus.empty       = (cnt_q == '0);

endmodule

// File: tb/tb_isq_sel_ctl.sv
// Self-checking bench for isq_sel_ctl; expected issue indices flow through a scoreboard queue.
module tb_isq_sel_ctl;
  import isq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  isq_sel_ctl_if bus ();

  isq_sel_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_q[$];
  logic exp_byp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int unsigned pdst, input int unsigned exp_idx);
    bus.alloc_req  = 1'b1;
    bus.alloc_pdst = preg_t'(pdst);
    #1;
    chk("alloc_gnt", 32'(bus.alloc_gnt), 1);
    chk("alloc_idx", 32'(bus.alloc_idx), exp_idx);
    step();
    bus.alloc_req = 1'b0;
  endtask

  // Issue monitor: every registered issue must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && bus.iss_vld) begin
      if (exp_q.size() == 0) chk("iss_unexp", 32'(bus.iss_vld), 0);
      else                   chk("iss_idx", 32'(bus.iss_idx), exp_q.pop_front());
    end
  end

  initial begin
`ifdef ISQ_WB_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    bus.flush        = 1'b0;
    bus.alloc_req    = 1'b0;
    bus.alloc_pdst   = '0;
    bus.wb_vld       = 1'b0;
    bus.wb_preg      = '0;
    bus.lin_inst_rdy = '0;
    bus.issue_stall  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_cnt", 32'(bus.cnt), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_vld", 32'(bus.lin_vld), 0);
    chk("rst_iss", 32'(bus.iss_vld), 0);

    // Three allocations, none ready: ready flops enabled with value 0.
    for (int unsigned k = 0; k < 3; k++) begin
      bus.alloc_req  = 1'b1;
      bus.alloc_pdst = preg_t'(5 + k);
      #1;
      chk("a3_gnt", 32'(bus.alloc_gnt), 1);
      chk("a3_idx", 32'(bus.alloc_idx), k);
      chk("a3_en", 32'(bus.lin_rdy_en), 32'(1) << k);
      chk("a3_val", 32'(bus.lin_rdy_val), 0);
      step();
    end
    bus.alloc_req = 1'b0;
    chk("a3_cnt", 32'(bus.cnt), 3);
    chk("a3_vld", 32'(bus.lin_vld), 32'h7);

    // Writeback hit on line 1, then a miss.
    bus.wb_vld  = 1'b1;
    bus.wb_preg = 6'd6;
    #1;
    chk("wb_en", 32'(bus.lin_rdy_en), 32'h0002);
    chk("wb_val", 32'(bus.lin_rdy_val), 32'h0002);
    bus.wb_preg = 6'd40;
    #1;
    chk("wb_miss", 32'(bus.lin_rdy_en), 0);
    bus.wb_vld = 1'b0;

    // Lines 1 and 2 ready: older first, head stays until line 0 issues.
    bus.lin_inst_rdy = 16'h0006;
    exp_q.push_back(1);
    exp_q.push_back(2);
    step();
    step();
    bus.lin_inst_rdy = '0;
    step();
    chk("sel_cnt", 32'(bus.cnt), 3);
    chk("sel_vld", 32'(bus.lin_vld), 32'h1);
    bus.lin_inst_rdy = 16'h0001;
    exp_q.push_back(0);
    step();
    bus.lin_inst_rdy = '0;
    chk("ret_cnt0", 32'(bus.cnt), 3);
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk("ret_cnt", 32'(bus.cnt), 2 - k);
    end
    chk("ret_empty", 32'(bus.empty), 1);

    // Flush to realign pointers at zero.
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl0_idx", 32'(bus.alloc_idx), 0);

    // Fill all 16 lines (pdst repeats every 8).
    for (int unsigned k = 0; k < ISQ_DEPTH; k++) alloc(k & 7, k);
    bus.alloc_req = 1'b1;
    #1;
    chk("full", 32'(bus.full), 1);
    chk("full_cnt", 32'(bus.cnt), 16);
    chk("full_gnt", 32'(bus.alloc_gnt), 0);
    step();
    bus.alloc_req = 1'b0;
    chk("full_cnt2", 32'(bus.cnt), 16);

    bus.wb_vld  = 1'b1;
    bus.wb_preg = 6'd3;
    #1;
    chk("wb_multi_en", 32'(bus.lin_rdy_en), 32'h0808);
    chk("wb_multi_val", 32'(bus.lin_rdy_val), 32'h0808);
    bus.wb_vld = 1'b0;

    // Issue line 0; retire one cycle later frees a slot at index 0.
    bus.lin_inst_rdy = 16'h0001;
    exp_q.push_back(0);
    step();
    bus.lin_inst_rdy = '0;
    chk("iss0_cnt", 32'(bus.cnt), 16);
    step();
    chk("wrap_cnt", 32'(bus.cnt), 15);
    chk("wrap_full", 32'(bus.full), 0);

    // Allocation with a concurrent matching writeback.
    bus.alloc_req  = 1'b1;
    bus.alloc_pdst = 6'd9;
    bus.wb_vld     = 1'b1;
    bus.wb_preg    = 6'd9;
    #1;
    chk("byp_gnt", 32'(bus.alloc_gnt), 1);
    chk("byp_idx", 32'(bus.alloc_idx), 0);
    chk("byp_en", 32'(bus.lin_rdy_en), 32'h0001);
    chk("byp_val", 32'(bus.lin_rdy_val), 32'(exp_byp));
    step();
    bus.alloc_req = 1'b0;
    bus.wb_vld    = 1'b0;
    chk("byp_cnt", 32'(bus.cnt), 16);

    // Stall holds everything, then flush wins over the pending issue.
    bus.lin_inst_rdy = '1;
    bus.issue_stall  = 1'b1;
    step();
    chk("stall_iss", 32'(bus.iss_vld), 0);
    chk("stall_vld", 32'(bus.lin_vld), 32'hFFFF);
    step();
    chk("stall_vld2", 32'(bus.lin_vld), 32'hFFFF);
    bus.issue_stall = 1'b0;
    bus.flush       = 1'b1;
    step();
    bus.flush        = 1'b0;
    bus.lin_inst_rdy = '0;
    chk("fl_cnt", 32'(bus.cnt), 0);
    chk("fl_empty", 32'(bus.empty), 1);
    chk("fl_vld", 32'(bus.lin_vld), 0);
    chk("fl_iss", 32'(bus.iss_vld), 0);

    // Async reset with an issue about to happen.
    alloc(1, 0);
    alloc(2, 1);
    bus.lin_inst_rdy = 16'h0003;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(bus.cnt), 0);
    chk("arst_vld", 32'(bus.lin_vld), 0);
    step();
    rst_n = 1'b1;
    bus.lin_inst_rdy = '0;
    step();
    chk("arst_iss", 32'(bus.iss_vld), 0);
    chk("arst_empty", 32'(bus.empty), 1);

    // Sparse ready pattern across four lines.
    for (int unsigned k = 0; k < 4; k++) alloc(k + 1, k);
    bus.lin_inst_rdy = 16'h000A;
    exp_q.push_back(1);
    exp_q.push_back(3);
    step();
    step();
    bus.lin_inst_rdy = '0;
    step();
    chk("pat_vld", 32'(bus.lin_vld), 32'h0005);
    chk("pat_cnt", 32'(bus.cnt), 4);

    chk("sb_pending", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
